// File: rtl/sr_flag_scheduler.sv
// sr_flag_scheduler: round-robin arbiter that shares one bank of SR latches among
// several requesters. Each granted request drives exactly one latch's s or r input
// for PULSE cycles, updates a shadow copy of the latch state and acknowledges.
module sr_flag_scheduler #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int PULSE = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0]                cmd,
  input  logic [NREQ*$clog2(NFLAG)-1:0]  idx,
  output logic [NREQ-1:0]                ack,
  output logic [NFLAG-1:0]               s,
  output logic [NFLAG-1:0]               r,
  output logic                           busy,
  output logic [NFLAG-1:0]               q_shdw
);

  localparam int IW = $clog2(NFLAG);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              cmd_q, cmd_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NFLAG-1:0]  s_q, s_d;
  logic [NFLAG-1:0]  r_q, r_d;
  logic              busy_q, busy_d;
  logic [NFLAG-1:0]  q_shdw_q, q_shdw_d;

  logic              any_req;
  logic [GW-1:0]     gnt_sel;
  logic              sel_cmd;
  logic [IW-1:0]     sel_idx;

  // Round-robin search: first requester with req=1 starting at rr_ptr, with wrap.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    any_req = 1'b0;
    gnt_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[(int'(rr_ptr_q) + i) % NREQ]) begin
        any_req = 1'b1;
        gnt_sel = GW'((int'(rr_ptr_q) + i) % NREQ);
      end
    end
    sel_cmd = cmd[gnt_sel];
    sel_idx = idx[int'(gnt_sel)*IW +: IW];
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    q_shdw_d = q_shdw_q;
    ack_d    = '0;
    s_d      = '0;
    r_d      = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d  = gnt_sel;
          cmd_d    = sel_cmd;
          idx_d    = sel_idx;
          rr_ptr_d = (int'(gnt_sel) == NREQ-1) ? '0 : gnt_sel + GW'(1);
          if (q_shdw_q[sel_idx] == sel_cmd) begin
            // Latch already holds the requested value: no drive, just acknowledge.
            state_d = RELEASE;
          end else begin
            state_d          = DRIVE;
            pcnt_d           = '0;
            s_d[sel_idx]     = sel_cmd;
            r_d[sel_idx]     = !sel_cmd;
          end
        end
      end

      DRIVE: begin
        if (pcnt_q == PW'(PULSE-1)) begin
          state_d         = RELEASE;
          q_shdw_d[idx_q] = cmd_q;
          ack_d[grant_q]  = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
          s_d    = s_q;
          r_d    = r_q;
        end
      end

      RELEASE: begin
        // A no-op arrives here with ack low; it raises ack one cycle later so that
        // its ack follows the grant cycle. A driven op arrives with ack already high.
        if (ack_q == '0) begin
          ack_d[grant_q] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cmd_q    <= 1'b0;
      idx_q    <= '0;
      pcnt_q   <= '0;
      ack_q    <= '0;
      s_q      <= '0;
      r_q      <= '0;
      busy_q   <= 1'b0;
      q_shdw_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      pcnt_q   <= pcnt_d;
      ack_q    <= ack_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      q_shdw_q <= q_shdw_d;
    end
  end

  assign ack    = ack_q;
  assign s      = s_q;
  assign r      = r_q;
  assign busy   = busy_q;
  assign q_shdw = q_shdw_q;

  // Latch-bank safety invariants.
  a_sr_excl:    assert property (@(posedge clk) (s_q & r_q) == '0);
  a_one_flag:   assert property (@(posedge clk) $onehot0(s_q | r_q));
  a_one_ack:    assert property (@(posedge clk) $onehot0(ack_q));
  a_ack_in_rel: assert property (@(posedge clk) (ack_q != '0) |-> (state_q == RELEASE));

endmodule
